// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_pkg
//  Description : Shared defaults and sensor-pair type for the traffic-light
//                controller and its input conditioner.
//  Revision    : 1.0
// ============================================================================
package traffic_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEFAULT_TICK_CYCLES     = 100_000_000;

    typedef struct packed {
        logic a;
        logic b;
    } sensor_pair_t;

endpackage : traffic_pkg
`default_nettype wire

// File: rtl/traffic_input_conditioner_if.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_input_conditioner_if
//  Description : Sensor / tick bundle between the environment and the
//                input conditioner.
//  Revision    : 1.0
// ============================================================================
interface traffic_input_conditioner_if;

    logic sa_raw;
    logic sb_raw;
    logic tick_en;
    logic tick;
    logic sa;
    logic sb;

    modport master (
        output sa_raw,
        output sb_raw,
        output tick_en,
        input  tick,
        input  sa,
        input  sb
    );

    modport slave (
        input  sa_raw,
        input  sb_raw,
        input  tick_en,
        output tick,
        output sa,
        output sb
    );

endinterface : traffic_input_conditioner_if
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_channel
//  Description : Two-flop synchroniser followed by a consecutive-mismatch
//                debounce counter for one raw sensor.
//  Revision    : 1.0
// ============================================================================
module debounce_channel #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  wire  clk,
    input  wire  reset,
    input  wire  raw,
    output logic level
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    generate
        if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
            $error("debounce_channel: DEBOUNCE_CYCLES must be >= 1");
        end
    endgenerate

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Any cycle agreeing with the current level restarts the count.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;

endmodule : debounce_channel
`default_nettype wire

// File: rtl/traffic_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_input_conditioner
//  Description : Debounces both car sensors, generates the FSM step tick and
//                holds the sensor view constant between ticks.
//  Revision    : 1.0
// ============================================================================
module traffic_input_conditioner
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int TICK_CYCLES     = DEFAULT_TICK_CYCLES
) (
    input  wire                          clk,
    input  wire                          reset,
    traffic_input_conditioner_if.slave   bus
);

    localparam int            PW        = $clog2(TICK_CYCLES);
    localparam logic [PW-1:0] PCNT_LAST = PW'(TICK_CYCLES - 1);

    generate
        if (TICK_CYCLES < 2) begin : g_bad_tick
            $error("traffic_input_conditioner: TICK_CYCLES must be >= 2");
        end
    endgenerate

    sensor_pair_t  db;
    sensor_pair_t  hold_q;
    sensor_pair_t  hold_d;
    logic [PW-1:0] pcnt_q;
    logic [PW-1:0] pcnt_d;
    logic          tick_q;
    logic          tick_d;
    logic          w_wrap;

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db_a (
        .clk   (clk),
        .reset (reset),
        .raw   (bus.sa_raw),
        .level (db.a)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db_b (
        .clk   (clk),
        .reset (reset),
        .raw   (bus.sb_raw),
        .level (db.b)
    );

    assign w_wrap = (pcnt_q == PCNT_LAST);

    // Prescaler freezes (not clears) while tick_en is low.
    always_comb begin
        pcnt_d = pcnt_q;
        tick_d = 1'b0;
        hold_d = hold_q;
        if (bus.tick_en) begin
            pcnt_d = w_wrap ? '0 : pcnt_q + 1'b1;
            tick_d = w_wrap;
        end
        if (tick_q) begin
            hold_d = db;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt_q <= '0;
            tick_q <= 1'b0;
            hold_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
            tick_q <= tick_d;
            hold_q <= hold_d;
        end
    end

    assign bus.tick = tick_q;
    assign bus.sa   = hold_q.a;
    assign bus.sb   = hold_q.b;

endmodule : traffic_input_conditioner
`default_nettype wire

// File: tb/tb_traffic_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_traffic_input_conditioner
//  Description : Directed bench for the input conditioner with
//                DEBOUNCE_CYCLES=4 and TICK_CYCLES=8.
//  Revision    : 1.0
// ============================================================================
module tb_traffic_input_conditioner;

    logic clk;
    logic reset;
    int   checks;
    int   fails;
    int   n;

    traffic_input_conditioner_if tif ();

    traffic_input_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .TICK_CYCLES     (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (tif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic checkn(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Edges until tick is seen high, bounded; the final check flags a timeout.
    task automatic wait_tick(output int edges);
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (tif.tick !== 1'b1 && edges < 40);
        check1("tick_seen", tif.tick, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        checks      = 0;
        fails       = 0;
        reset       = 1'b1;
        tif.sa_raw  = 1'b0;
        tif.sb_raw  = 1'b0;
        tif.tick_en = 1'b0;

        // Reset state and first tick after release
        step(2);
        check1("rst_tick", tif.tick, 1'b0);
        check1("rst_sa", tif.sa, 1'b0);
        check1("rst_sb", tif.sb, 1'b0);
        reset       = 1'b0;
        tif.tick_en = 1'b1;
        wait_tick(n);
        checkn("first_tick_edges", n, 8);
        step(1);
        check1("tick_width", tif.tick, 1'b0);
        wait_tick(n);
        checkn("tick_period", n, 7);

        // Debounced rise of A and its transfer on the next tick
        tif.sa_raw = 1'b1;
        step(5);
        check1("db_a_before", dut.u_db_a.level_q, 1'b0);
        step(1);
        check1("db_a_rise", dut.u_db_a.level_q, 1'b1);
        check1("sa_held_low", tif.sa, 1'b0);
        step(2);
        check1("tick_ph8", tif.tick, 1'b1);
        check1("sa_at_tick", tif.sa, 1'b0);
        step(1);
        check1("sa_after_tick", tif.sa, 1'b1);
        step(8);
        check1("sa_stays", tif.sa, 1'b1);

        // Short pulses on B never pass the debouncer
        tif.sb_raw = 1'b1;
        step(3);
        tif.sb_raw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            check1("db_b_short3", dut.u_db_b.level_q, 1'b0);
        end
        tif.sb_raw = 1'b1;
        step(3);
        tif.sb_raw = 1'b0;
        step(1);
        tif.sb_raw = 1'b1;
        step(3);
        tif.sb_raw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            check1("db_b_glitch", dut.u_db_b.level_q, 1'b0);
        end
        check1("sb_low", tif.sb, 1'b0);

        // Prescaler freeze
        wait_tick(n);
        step(3);
        tif.tick_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check1("no_tick_frozen", tif.tick, 1'b0);
        end
        tif.tick_en = 1'b1;
        wait_tick(n);
        checkn("tick_after_freeze", n, 5);
        wait_tick(n);
        checkn("period_resumed", n, 8);

        // Asynchronous reset mid-period
        step(5);
        check1("sa_before_rst", tif.sa, 1'b1);
        reset = 1'b1;
        #1;
        check1("async_sa", tif.sa, 1'b0);
        check1("async_tick", tif.tick, 1'b0);
        checkn("async_pcnt", int'(dut.pcnt_q), 0);
        step(2);
        reset = 1'b0;
        wait_tick(n);
        checkn("tick_after_rst", n, 8);
        check1("sa_at_rst_tick", tif.sa, 1'b0);
        step(1);
        check1("sa_rerise", tif.sa, 1'b1);

        // Simultaneous change of both channels
        tif.sa_raw = 1'b0;
        tif.sb_raw = 1'b1;
        wait_tick(n);
        checkn("both_tick_edges", n, 7);
        check1("both_sa_old", tif.sa, 1'b1);
        check1("both_sb_old", tif.sb, 1'b0);
        step(1);
        check1("both_sa_new", tif.sa, 1'b0);
        check1("both_sb_new", tif.sb, 1'b1);

        // A change just after a tick waits a full period
        tif.sa_raw = 1'b1;
        step(6);
        check1("db_a_back", dut.u_db_a.level_q, 1'b1);
        check1("sa_still_held", tif.sa, 1'b0);
        step(1);
        check1("late_tick", tif.tick, 1'b1);
        check1("sa_at_late_tick", tif.sa, 1'b0);
        step(1);
        check1("sa_late_update", tif.sa, 1'b1);
        check1("sb_kept", tif.sb, 1'b1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule : tb_traffic_input_conditioner
`default_nettype wire
